// File: rtl/color_det_pkg.sv
// Shared encodings and helpers for the multi-class colour detector.
package color_det_pkg;

  localparam logic [1:0] CB_MIN = 2'd0;
  localparam logic [1:0] CB_MAX = 2'd1;
  localparam logic [1:0] CR_MIN = 2'd2;
  localparam logic [1:0] CR_MAX = 2'd3;

  localparam logic [1:0] MARK_PREFIX = 2'b01;

  function automatic int unsigned cid_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/color_window_cmp.sv
// One colour class: Cb/Cr threshold registers plus the registered stage-1 window compare.
module color_window_cmp
  import color_det_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [1:0]        cfg_field_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  input  logic              pix_en_i,
  input  logic [DATA_W-1:0] cb_i,
  input  logic [DATA_W-1:0] cr_i,
  output logic              raw_o
);

  logic [DATA_W-1:0] cb_min_q, cb_min_d, cb_max_q, cb_max_d;
  logic [DATA_W-1:0] cr_min_q, cr_min_d, cr_max_q, cr_max_d;
  logic              raw_q, raw_d;

  always_comb begin
    cb_min_d = cb_min_q;
    cb_max_d = cb_max_q;
    cr_min_d = cr_min_q;
    cr_max_d = cr_max_q;
    if (cfg_we_i) begin
      unique case (cfg_field_i)
        CB_MIN: cb_min_d = cfg_data_i;
        CB_MAX: cb_max_d = cfg_data_i;
        CR_MIN: cr_min_d = cfg_data_i;
        CR_MAX: cr_max_d = cfg_data_i;
      endcase
    end
    // Compare against the registered thresholds so a write lands on the next pixel.
    raw_d = raw_q;
    if (pix_en_i) begin
      raw_d = (cb_i >= cb_min_q) && (cb_i <= cb_max_q) &&
              (cr_i >= cr_min_q) && (cr_i <= cr_max_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cb_min_q <= '1;
      cb_max_q <= '0;
      cr_min_q <= '1;
      cr_max_q <= '0;
      raw_q    <= 1'b0;
    end else begin
      cb_min_q <= cb_min_d;
      cb_max_q <= cb_max_d;
      cr_min_q <= cr_min_d;
      cr_max_q <= cr_max_d;
      raw_q    <= raw_d;
    end
  end

  assign raw_o = raw_q;

endmodule

// File: rtl/color_detector_multi.sv
// Multi-class YCbCr colour detector with luminance marking and per-frame hit counts.
// Optional run-length filter enabled by defining COLOR_DETECT_RUN_FILTER_EN.
module color_detector_multi
  import color_det_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned N_CLASS = 4,
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned MIN_RUN = 4,
  localparam int unsigned CID_W  = cid_width(N_CLASS)
) (
  input  logic                     PCLK,
  input  logic                     reset,
  input  logic                     e_pix,
  input  logic [DATA_W-1:0]        Y,
  input  logic [DATA_W-1:0]        Cb,
  input  logic [DATA_W-1:0]        Cr,
  input  logic                     line_start,
  input  logic                     frame_end,
  input  logic                     cfg_we,
  input  logic [CID_W-1:0]         cfg_class,
  input  logic [1:0]               cfg_field,
  input  logic [DATA_W-1:0]        cfg_data,
  output logic                     pix_valid,
  output logic [N_CLASS-1:0]       hit,
  output logic [CID_W-1:0]         class_id,
  output logic [DATA_W-1:0]        Y_out,
  output logic                     count_valid,
  output logic [N_CLASS*CNT_W-1:0] count_out
);

  localparam int unsigned RUN_W = (MIN_RUN < 1) ? 1 : $clog2(MIN_RUN + 1);

  logic [N_CLASS-1:0]       raw, hit_now;
  logic                     v1_q, v1_d;
  logic [DATA_W-1:0]        y1_q, y1_d;
  logic                     pix_valid_q, pix_valid_d;
  logic [N_CLASS-1:0]       hit_q, hit_d;
  logic [CID_W-1:0]         class_id_q, class_id_d;
  logic [DATA_W-1:0]        y_out_q, y_out_d;
  logic                     count_valid_q, count_valid_d;
  logic [N_CLASS*CNT_W-1:0] count_out_q, count_out_d;
  logic [CNT_W-1:0]         cnt_q [N_CLASS];
  logic [CNT_W-1:0]         cnt_d [N_CLASS];
  logic [CNT_W-1:0]         cnt_nxt [N_CLASS];

  for (genvar c = 0; c < N_CLASS; c++) begin : g_cls
    color_window_cmp #(
      .DATA_W(DATA_W)
    ) u_cmp (
      .clk_i      (PCLK),
      .rst_i      (reset),
      .cfg_we_i   (cfg_we && (cfg_class == CID_W'(c))),
      .cfg_field_i(cfg_field),
      .cfg_data_i (cfg_data),
      .pix_en_i   (e_pix),
      .cb_i       (Cb),
      .cr_i       (Cr),
      .raw_o      (raw[c])
    );
  end

`ifdef COLOR_DETECT_RUN_FILTER_EN
  // line_start is delayed to stage 1 so it lines up with the pixel sampled alongside it.
  logic             ls1_q, ls1_d;
  logic [RUN_W-1:0] run_q [N_CLASS];
  logic [RUN_W-1:0] run_d [N_CLASS];
  logic [RUN_W-1:0] run_base;

  always_comb begin
    ls1_d    = line_start;
    run_base = '0;
    hit_now  = '0;
    for (int c = 0; c < int'(N_CLASS); c++) begin
      run_base = ls1_q ? '0 : run_q[c];
      run_d[c] = run_base;
      if (v1_q) begin
        if (raw[c]) begin
          run_d[c] = (run_base >= RUN_W'(MIN_RUN)) ? RUN_W'(MIN_RUN) : run_base + 1'b1;
        end else begin
          run_d[c] = '0;
        end
        hit_now[c] = raw[c] && (run_d[c] >= RUN_W'(MIN_RUN));
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      ls1_q <= 1'b0;
      for (int c = 0; c < int'(N_CLASS); c++) run_q[c] <= '0;
    end else begin
      ls1_q <= ls1_d;
      for (int c = 0; c < int'(N_CLASS); c++) run_q[c] <= run_d[c];
    end
  end
`else
  logic [RUN_W-1:0] unused_run_sink;
  assign unused_run_sink = {RUN_W{line_start}};
  assign hit_now = raw;
`endif

  always_comb begin
    v1_d          = e_pix;
    y1_d          = e_pix ? Y : y1_q;
    pix_valid_d   = v1_q;
    hit_d         = hit_q;
    class_id_d    = class_id_q;
    y_out_d       = y_out_q;
    if (v1_q) begin
      hit_d      = hit_now;
      class_id_d = '0;
      for (int c = int'(N_CLASS) - 1; c >= 0; c--) begin
        if (hit_now[c]) class_id_d = CID_W'(c);
      end
      y_out_d = (|hit_now) ? {MARK_PREFIX, y1_q[DATA_W-1:2]} : y1_q;
    end

    // Counting runs off the stage-2 registers; a stage-1 pixel belongs to the next frame.
    count_valid_d = frame_end;
    count_out_d   = count_out_q;
    for (int c = 0; c < int'(N_CLASS); c++) begin
      cnt_nxt[c] = cnt_q[c];
      if (pix_valid_q && hit_q[c] && (cnt_q[c] != {CNT_W{1'b1}})) begin
        cnt_nxt[c] = cnt_q[c] + 1'b1;
      end
      cnt_d[c] = frame_end ? '0 : cnt_nxt[c];
      if (frame_end) count_out_d[c*CNT_W +: CNT_W] = cnt_nxt[c];
    end
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      v1_q          <= 1'b0;
      y1_q          <= '0;
      pix_valid_q   <= 1'b0;
      hit_q         <= '0;
      class_id_q    <= '0;
      y_out_q       <= '0;
      count_valid_q <= 1'b0;
      count_out_q   <= '0;
      for (int c = 0; c < int'(N_CLASS); c++) cnt_q[c] <= '0;
    end else begin
      v1_q          <= v1_d;
      y1_q          <= y1_d;
      pix_valid_q   <= pix_valid_d;
      hit_q         <= hit_d;
      class_id_q    <= class_id_d;
      y_out_q       <= y_out_d;
      count_valid_q <= count_valid_d;
      count_out_q   <= count_out_d;
      for (int c = 0; c < int'(N_CLASS); c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign pix_valid   = pix_valid_q;
  assign hit         = hit_q;
  assign class_id    = class_id_q;
  assign Y_out       = y_out_q;
  assign count_valid = count_valid_q;
  assign count_out   = count_out_q;

endmodule
